// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external combinational ALU for single ops and a shift-and-add multiply; owns PSR {N,Z,C,V}.
// Latency: ALU op response sampled 2 edges after acceptance, multiply word_Size+1 (shorter when MUL_EARLY_EXIT_EN is defined).
// Backpressure: response held in DONE until rsp_ready; req_ready only while IDLE, so requests never overlap.
module alu_sequencer #(
    parameter int word_Size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_op,
    input  logic [word_Size-1:0] req_a,
    input  logic [word_Size-1:0] req_b,
    output logic [3:0]           alu_G,
    output logic [word_Size-1:0] alu_A,
    output logic [word_Size-1:0] alu_B,
    input  logic [word_Size-1:0] alu_Result,
    input  logic                 alu_C,
    input  logic                 alu_V,
    input  logic                 alu_PSR_Write,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [word_Size-1:0] rsp_data,
    output logic [3:0]           psr,
    output logic                 busy
);

    localparam int CW = (word_Size > 1) ? $clog2(word_Size) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           g_q;
    // a_q doubles as the multiplicand and b_q as the multiplier during MUL.
    logic [word_Size-1:0] a_q;
    logic [word_Size-1:0] b_q;
    logic [word_Size-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 mul_last;

    always_comb begin
        state_nxt = state;
        alu_G     = 4'b0000;
        alu_A     = '0;
        alu_B     = '0;
        mul_last  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_op[4] ? MUL : EXEC;
                end
            end
            EXEC: begin
                alu_G     = g_q;
                alu_A     = a_q;
                alu_B     = b_q;
                state_nxt = DONE;
            end
            MUL: begin
                alu_A = acc_q;
                if (b_q[0]) begin
                    alu_G = 4'b0010;
                    alu_B = a_q;
                end
`ifdef MUL_EARLY_EXIT_EN
                mul_last = (cnt_q == CW'(word_Size - 1)) || ((b_q >> 1) == '0);
`else
                mul_last = (cnt_q == CW'(word_Size - 1));
`endif
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            g_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rsp_data <= '0;
            psr      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        g_q   <= req_op[3:0];
                        a_q   <= req_a;
                        b_q   <= req_b;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_Result;
                    if (alu_PSR_Write) begin
                        psr <= {alu_Result[word_Size-1], (alu_Result == '0), alu_C, alu_V};
                    end
                end
                MUL: begin
                    acc_q <= alu_Result;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    // Product flags come from the final sum, never from the ALU's own carry/overflow.
                    if (mul_last) begin
                        rsp_data <= alu_Result;
                        psr      <= {alu_Result[word_Size-1], (alu_Result == '0), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the alu_* port, reference results from plain arithmetic.
module tb_alu_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [4:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_ready, rsp_valid, busy;
    logic         alu_C, alu_V, alu_PSR_Write;
    logic [3:0]   alu_G, psr;
    logic [W-1:0] alu_A, alu_B, alu_Result, rsp_data;

    int           checks = 0;
    int           failures = 0;
    logic [3:0]   psr_m = '0;
    logic [4:0]   r_op;
    logic [W-1:0] r_a, r_b;

    always #5 clk = ~clk;

    alu_sequencer #(.word_Size(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_G(alu_G), .alu_A(alu_A), .alu_B(alu_B),
        .alu_Result(alu_Result), .alu_C(alu_C), .alu_V(alu_V), .alu_PSR_Write(alu_PSR_Write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .psr(psr), .busy(busy)
    );

    // Returns {psr_write, C, V, result}; arithmetic codes (G[3]=0) update flags, logic codes do not.
    function automatic logic [W+2:0] alu_fn(input logic [3:0] g, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [W:0]   s;
        logic         cin, c, v;
        y = '0; r = '0; s = '0; cin = 1'b0; c = 1'b0; v = 1'b0;
        if (!g[3]) begin
            case (g[2:0])
                3'd1:    cin = 1'b1;
                3'd2:    y = b;
                3'd3:    begin y = b; cin = 1'b1; end
                3'd4:    y = ~b;
                3'd5:    begin y = ~b; cin = 1'b1; end
                3'd6:    y = '1;
                default: y = '0;
            endcase
            s = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, cin};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == y[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            case (g[2:0])
                3'd0:    r = a & b;
                3'd1:    r = a | b;
                3'd2:    r = a ^ b;
                3'd3:    r = ~a;
                3'd4:    r = a << 1;
                3'd5:    r = a >> 1;
                3'd6:    r = b;
                default: r = ~b;
            endcase
        end
        return {~g[3], c, v, r};
    endfunction

    assign {alu_PSR_Write, alu_C, alu_V, alu_Result} = alu_fn(alu_G, alu_A, alu_B);

    function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_d;
        logic [W+2:0] f;
        int           lat, k;
        if (op[4]) begin
            exp_d = a * b;
            lat   = mul_lat(b);
            psr_m = {exp_d[W-1], (exp_d == '0), 2'b00};
        end else begin
            f     = alu_fn(op[3:0], a, b);
            exp_d = f[W-1:0];
            lat   = 2;
            if (f[W+2]) psr_m = {f[W-1], (f[W-1:0] == '0), f[W+1], f[W]};
        end
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        // Keep a garbage request pending to prove nothing else gets accepted.
        req_op = 5'($urandom); req_a = $urandom; req_b = $urandom;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_req_ready", 64'(req_ready), 64'd0);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 64'(k), 64'(lat - 1));
        chk("rsp_data", 64'(rsp_data), 64'(exp_d));
        chk("psr", 64'(psr), 64'(psr_m));
        chk("alu_idle_in_done", 64'(alu_A | alu_B | {{(W-4){1'b0}}, alu_G}), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", 64'(rsp_data), 64'(exp_d));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("released_valid", 64'(rsp_valid), 64'd0);
        chk("released_req_ready", 64'(req_ready), 64'd1);
        chk("released_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_psr", 64'(psr), 64'd0);
        chk("rst_alu_G", 64'(alu_G), 64'd0);
        chk("rst_alu_A", 64'(alu_A), 64'd0);
        chk("rst_alu_B", 64'(alu_B), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        run_op(5'b00101, 32'd5, 32'd5, 0);
        chk("sub_psr", 64'(psr), 64'h6);
        run_op(5'b01000, 32'hF0, 32'h3C, 0);
        chk("and_psr_kept", 64'(psr), 64'h6);
        run_op(5'b10000, 32'd7, 32'd6, 5);
        chk("mul_psr", 64'(psr), 64'h0);
        run_op(5'b00101, 32'd0, 32'd1, 1);
        chk("neg_psr", 64'(psr), 64'h8);

        // Reset in the middle of a long multiply.
        req_valid = 1'b1; req_op = 5'b10000; req_a = 32'hFFFF; req_b = 32'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("mul_mid_busy", 64'(busy), 64'd1);
        chk("mul_mid_G", 64'(alu_G), 64'h2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_psr", 64'(psr), 64'd0);
        chk("midrst_alu_G", 64'(alu_G), 64'd0);
        chk("midrst_alu_A", 64'(alu_A), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        psr_m = '0;

        run_op(5'b10000, 32'd0, 32'h1234_5678, 0);
        chk("mul_zero_psr", 64'(psr), 64'h4);
        run_op(5'b11111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'b10000, 32'h8000_0001, 32'd0, 0);

        for (int n = 0; n < 24; n++) begin
            r_op = 5'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case (n % 4)
                0: begin r_op[4] = 1'b1; r_b = W'($urandom_range(0, 15)); end
                1: begin r_op[4] = 1'b1; if (n % 8 == 1) r_a = '0; end
                default: r_op[4] = 1'b0;
            endcase
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
